// File: rtl/rf_ctrl_pkg.sv
// rtl/rf_ctrl_pkg.sv - shared types and constants for the register-file write controller
//
// Purpose: default widths, register count, controller state encoding and
//          requester indices used by rf_write_arbiter and rr_arbiter2.
// Ports:   none (package).
package rf_ctrl_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 2 ** RF_ADDR_W;

  // Requester indices; also used as the prio_q value that favours each source.
  localparam logic REQ_EXEC = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with its priority register
//
// Purpose: grants one of two valid requesters per cycle; when both are valid
//          the favoured one (prio_q) wins, and every grant hands priority to
//          the other requester.
// Ports:   i_clk, i_rst (async, active-high)
//          i_valid0, i_valid1  request valids
//          i_en                grants are allowed this cycle
//          o_grant0, o_grant1  one-hot-or-zero grants (combinational)
module rr_arbiter2
  import rf_ctrl_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_en,
  output logic o_grant0,
  output logic o_grant1
);

  logic r_prio;
  logic w_grant0;
  logic w_grant1;

  always_comb begin
    w_grant0 = i_en && i_valid0 && (!i_valid1 || (r_prio == REQ_EXEC));
    w_grant1 = i_en && i_valid1 && (!i_valid0 || (r_prio == REQ_LOAD));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prio <= REQ_EXEC;
    end else if (w_grant0) begin
      r_prio <= REQ_LOAD;
    end else if (w_grant1) begin
      r_prio <= REQ_EXEC;
    end
  end

  assign o_grant0 = w_grant0;
  assign o_grant1 = w_grant1;

endmodule

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register-file write-port controller with sequenced clear
//
// Purpose: round-robin arbitration between execute (req0) and load (req1)
//          writebacks onto the single register-file write port through a
//          registered output stage, plus a clear sequence that writes zero
//          to registers 1..NUM_REGS-1, one per cycle.
// Config:  RF_ARB_FORWARD_EN adds write-to-read forwarding ports.
// Ports:   clk_i, reset_i (async, active-high)
//          reqN_valid_i/addr_i/data_i, reqN_ready_o  write requesters 0 and 1
//          clear_i                                  start clear sequence
//          busy_o, clear_done_o                     clear status
//          we_o, wd_addr_o, wd_o                    register-file write port
//          addr1_i, addr2_i, rd1_i, rd2_i, rd1_o, rd2_o  forwarding (optional)
module rf_write_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req0_valid_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_ready_o,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              clear_done_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] wd_addr_o,
  output logic [DATA_W-1:0] wd_o
`ifdef RF_ARB_FORWARD_EN
  ,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [ADDR_W-1:0] addr2_i,
  input  logic [DATA_W-1:0] rd1_i,
  input  logic [DATA_W-1:0] rd2_i,
  output logic [DATA_W-1:0] rd1_o,
  output logic [DATA_W-1:0] rd2_o
`endif
);

  localparam int                NUM_REGS  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic              r_we;
  logic              w_we_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_arb_en;
  logic              w_grant0;
  logic              w_grant1;

  // A clear request pre-empts arbitration in the same cycle; the request waits.
  assign w_arb_en = (r_state == ST_RUN) && !clear_i;

  rr_arbiter2 u_arb (
    .i_clk    (clk_i),
    .i_rst    (reset_i),
    .i_valid0 (req0_valid_i),
    .i_valid1 (req1_valid_i),
    .i_en     (w_arb_en),
    .o_grant0 (w_grant0),
    .o_grant1 (w_grant1)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (clear_i) begin
          // Entry edge already issues the write to register 1.
          w_state_nxt = ST_CLEAR;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = ADDR_W'(1);
          w_data_nxt  = '0;
          w_cnt_nxt   = ADDR_W'(2);
        end else if (w_grant0) begin
          // Writes to register 0 are accepted but never reach the file.
          w_we_nxt   = (req0_addr_i != '0);
          w_addr_nxt = req0_addr_i;
          w_data_nxt = req0_data_i;
        end else if (w_grant1) begin
          w_we_nxt   = (req1_addr_i != '0);
          w_addr_nxt = req1_addr_i;
          w_data_nxt = req1_data_i;
        end
      end
      ST_CLEAR: begin
        w_we_nxt   = 1'b1;
        w_addr_nxt = r_cnt;
        w_data_nxt = '0;
        w_cnt_nxt  = r_cnt + 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = ST_RUN;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign req0_ready_o = w_grant0;
  assign req1_ready_o = w_grant1;
  assign busy_o       = (r_state == ST_CLEAR);
  assign clear_done_o = r_done;
  assign we_o         = r_we;
  assign wd_addr_o    = r_addr;
  assign wd_o         = r_data;

`ifdef RF_ARB_FORWARD_EN
  // Bypass the write still sitting in the output stage, which the register
  // file only commits at the next edge.
  always_comb begin
    rd1_o = (r_we && (addr1_i != '0) && (addr1_i == r_addr)) ? r_data : rd1_i;
    rd2_o = (r_we && (addr2_i != '0) && (addr2_i == r_addr)) ? r_data : rd2_i;
  end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2 ** AW;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          req0_valid_i, req1_valid_i;
  logic [AW-1:0] req0_addr_i, req1_addr_i;
  logic [DW-1:0] req0_data_i, req1_data_i;
  logic          req0_ready_o, req1_ready_o;
  logic          clear_i;
  logic          busy_o, clear_done_o, we_o;
  logic [AW-1:0] wd_addr_o;
  logic [DW-1:0] wd_o;
`ifdef RF_ARB_FORWARD_EN
  logic [AW-1:0] addr1_i, addr2_i;
  logic [DW-1:0] rd1_i, rd2_i, rd1_o, rd2_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .req0_valid_i (req0_valid_i),
    .req0_addr_i  (req0_addr_i),
    .req0_data_i  (req0_data_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_addr_i  (req1_addr_i),
    .req1_data_i  (req1_data_i),
    .req1_ready_o (req1_ready_o),
    .clear_i      (clear_i),
    .busy_o       (busy_o),
    .clear_done_o (clear_done_o),
    .we_o         (we_o),
    .wd_addr_o    (wd_addr_o),
    .wd_o         (wd_o)
`ifdef RF_ARB_FORWARD_EN
    ,
    .addr1_i      (addr1_i),
    .addr2_i      (addr2_i),
    .rd1_i        (rd1_i),
    .rd2_i        (rd2_i),
    .rd1_o        (rd1_o),
    .rd2_o        (rd2_o)
`endif
  );

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    req0_valid_i = 1'b0; req0_addr_i = '0; req0_data_i = '0;
    req1_valid_i = 1'b0; req1_addr_i = '0; req1_data_i = '0;
    clear_i      = 1'b0;
`ifdef RF_ARB_FORWARD_EN
    addr1_i = '0; addr2_i = '0; rd1_i = '0; rd2_i = '0;
`endif
  endtask

  task automatic apply_reset;
    idle_inputs();
    reset_i = 1'b1;
    next_cycle();
    reset_i = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset_i = 1'b1;
    #1;
    n_checks++;
    if ({we_o, busy_o, clear_done_o} !== 3'b000 || wd_addr_o !== '0 || wd_o !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b busy=%b done=%b addr=%0d data=%h expected all 0",
               we_o, busy_o, clear_done_o, wd_addr_o, wd_o);
    end
    next_cycle();
    reset_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (we_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got we=%b busy=%b expected 0 0", we_o, busy_o);
    end
    n_checks++;
    if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: got %b%b expected 00", req0_ready_o, req1_ready_o);
    end
    next_cycle();
  endtask

  task automatic test_single;
    apply_reset();
    req0_valid_i = 1'b1; req0_addr_i = 5'd5; req0_data_i = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ready: got %b%b expected 10", req0_ready_o, req1_ready_o);
    end
    next_cycle();
    req0_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (we_o !== 1'b1 || wd_addr_o !== 5'd5 || wd_o !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL single_write: got we=%b addr=%0d data=%h expected 1 5 deadbeef",
               we_o, wd_addr_o, wd_o);
    end
    next_cycle();
  endtask

  task automatic test_alternate;
    apply_reset();
    req0_valid_i = 1'b1; req0_addr_i = 5'd3; req0_data_i = 32'h3333_0000;
    req1_valid_i = 1'b1; req1_addr_i = 5'd7; req1_data_i = 32'h7777_0000;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
      end
      @(negedge clk);
      if (i < 4) begin
        n_checks++;
        if (req0_ready_o !== (i % 2 == 0) || req1_ready_o !== (i % 2 == 1)) begin
          n_fail++;
          $display("FAIL alt_grant[%0d]: got %b%b expected %b%b", i, req0_ready_o,
                   req1_ready_o, (i % 2 == 0), (i % 2 == 1));
        end
      end
      n_checks++;
      if (i == 0) begin
        if (we_o !== 1'b0) begin
          n_fail++;
          $display("FAIL alt_first_we: got %b expected 0", we_o);
        end
      end else if (we_o !== 1'b1 || wd_addr_o !== ((i % 2 == 1) ? 5'd3 : 5'd7)) begin
        n_fail++;
        $display("FAIL alt_write[%0d]: got we=%b addr=%0d expected 1 %0d", i, we_o,
                 wd_addr_o, (i % 2 == 1) ? 3 : 7);
      end
      next_cycle();
    end
  endtask

  task automatic test_addr_zero;
    apply_reset();
    req1_valid_i = 1'b1; req1_addr_i = '0; req1_data_i = 32'h1234;
    @(negedge clk);
    n_checks++;
    if (req1_ready_o !== 1'b1 || req0_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_ready: got %b%b expected 01", req0_ready_o, req1_ready_o);
    end
    next_cycle();
    req1_valid_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (we_o !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_dropped: got we=%b expected 0", we_o);
    end
    next_cycle();
    req0_valid_i = 1'b1; req0_addr_i = 5'd4; req0_data_i = 32'h4;
    req1_valid_i = 1'b1; req1_addr_i = 5'd6; req1_data_i = 32'h6;
    @(negedge clk);
    n_checks++;
    if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_prio_flip: got %b%b expected 10", req0_ready_o, req1_ready_o);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_clear;
    apply_reset();
    req0_valid_i = 1'b1; req0_addr_i = 5'd12; req0_data_i = 32'hC0FFEE12;
    clear_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_wins: got ready=%b%b busy=%b expected 00 0", req0_ready_o,
               req1_ready_o, busy_o);
    end
    next_cycle();
    clear_i = 1'b0;
    for (int k = 1; k < NR; k++) begin
      @(negedge clk);
      n_checks++;
      if (we_o !== 1'b1 || wd_addr_o !== AW'(k) || wd_o !== '0) begin
        n_fail++;
        $display("FAIL clear_write[%0d]: got we=%b addr=%0d data=%h expected 1 %0d 0", k,
                 we_o, wd_addr_o, wd_o, k);
      end
      n_checks++;
      if (clear_done_o !== (k == NR - 1) || busy_o !== (k != NR - 1)) begin
        n_fail++;
        $display("FAIL clear_status[%0d]: got done=%b busy=%b expected %b %b", k,
                 clear_done_o, busy_o, (k == NR - 1), (k != NR - 1));
      end
      n_checks++;
      if (req0_ready_o !== (k == NR - 1)) begin
        n_fail++;
        $display("FAIL clear_ready[%0d]: got %b expected %b", k, req0_ready_o, (k == NR - 1));
      end
      next_cycle();
      if (k == NR - 1) req0_valid_i = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (we_o !== 1'b1 || wd_addr_o !== 5'd12 || wd_o !== 32'hC0FFEE12 ||
        clear_done_o !== 1'b0 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_then_req: got we=%b addr=%0d data=%h done=%b busy=%b expected 1 12 c0ffee12 0 0",
               we_o, wd_addr_o, wd_o, clear_done_o, busy_o);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_clear;
    bit found;
    apply_reset();
    clear_i = 1'b1;
    next_cycle();
    clear_i = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (wd_addr_o == 5'd10 && we_o == 1'b1) found = 1'b1;
      else next_cycle();
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL midclear_reach10: got no write to addr 10 within 40 cycles expected one");
    end
    reset_i = 1'b1;
    #1;
    n_checks++;
    if ({we_o, busy_o, clear_done_o} !== 3'b000 || wd_addr_o !== '0 || wd_o !== '0) begin
      n_fail++;
      $display("FAIL midclear_async: got we=%b busy=%b done=%b addr=%0d expected all 0",
               we_o, busy_o, clear_done_o, wd_addr_o);
    end
    next_cycle();
    reset_i = 1'b0;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      n_checks++;
      if (we_o !== 1'b0 || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL midclear_quiet[%0d]: got we=%b busy=%b expected 0 0", c, we_o, busy_o);
      end
      next_cycle();
    end
  endtask

  // Reference: each requester holds one pending write until it is granted;
  // "fav" names the requester that wins a tie and flips to the other after any grant.
  task automatic test_random;
    bit            pend [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    int            fav;
    bit            g0, g1, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    apply_reset();
    fav = 0; m_we = 1'b0; m_addr = '0; m_data = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;
    repeat (300) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) != 0) begin
          pend[r] = 1'b1;
          a[r] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
          d[r] = $urandom;
        end
      end
      req0_valid_i = pend[0]; req0_addr_i = a[0]; req0_data_i = d[0];
      req1_valid_i = pend[1]; req1_addr_i = a[1]; req1_data_i = d[1];
      g0 = pend[0] && (!pend[1] || fav == 0);
      g1 = pend[1] && !g0;
      @(negedge clk);
      n_checks++;
      if (req0_ready_o !== g0 || req1_ready_o !== g1) begin
        n_fail++;
        $display("FAIL rand_grant: got %b%b expected %b%b", req0_ready_o, req1_ready_o, g0, g1);
      end
      n_checks++;
      if (we_o !== m_we || busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_we: got we=%b busy=%b expected %b 0", we_o, busy_o, m_we);
      end
      if (m_we) begin
        n_checks++;
        if (wd_addr_o !== m_addr || wd_o !== m_data) begin
          n_fail++;
          $display("FAIL rand_write: got addr=%0d data=%h expected %0d %h", wd_addr_o, wd_o,
                   m_addr, m_data);
        end
      end
      @(posedge clk);
      if (g0) begin
        m_we = (a[0] != '0); m_addr = a[0]; m_data = d[0]; pend[0] = 1'b0; fav = 1;
      end else if (g1) begin
        m_we = (a[1] != '0); m_addr = a[1]; m_data = d[1]; pend[1] = 1'b0; fav = 0;
      end else begin
        m_we = 1'b0;
      end
      #1;
    end
    idle_inputs();
    next_cycle();
  endtask

`ifdef RF_ARB_FORWARD_EN
  task automatic test_forward;
    apply_reset();
    req0_valid_i = 1'b1; req0_addr_i = 5'd9; req0_data_i = 32'hA5A5A5A5;
    next_cycle();
    req0_valid_i = 1'b0;
    addr1_i = 5'd9; rd1_i = '0;
    addr2_i = 5'd9; rd2_i = 32'h11;
    #1;
    n_checks++;
    if (rd1_o !== 32'hA5A5A5A5 || rd2_o !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL fwd_hit: got rd1=%h rd2=%h expected a5a5a5a5 a5a5a5a5", rd1_o, rd2_o);
    end
    addr1_i = '0; rd1_i = 32'h77;
    addr2_i = 5'd8;
    #1;
    n_checks++;
    if (rd1_o !== 32'h77 || rd2_o !== 32'h11) begin
      n_fail++;
      $display("FAIL fwd_miss: got rd1=%h rd2=%h expected 77 11", rd1_o, rd2_o);
    end
    idle_inputs();
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_addr_zero();
    test_clear();
    test_reset_mid_clear();
    test_random();
`ifdef RF_ARB_FORWARD_EN
    test_forward();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
